mm_io_bridge: RTL
=================

# mm_io_bridge

Host-side I/O adapter for the micromachine. Buffers words from a host valid/ready stream and presents them on the machine's `din`, popping one word per `din_strb`. Captures each `dout` word qualified by `dout_strb` into a second buffer drained by the host over valid/ready. It is the peer of the machine's strobe interface and sits between the micromachine top and the testbench or host fabric.

## Interface
Parameters:
- `WIDTH`, default `globals::WORDLEN`: data word width.
- `DEPTH`, default 4: entries per FIFO. Must be a power of two and at least 2.

Ports:
- `clk`  in  1  the single clock; every register updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `host_in_data`  in  WIDTH  word written toward the machine.
- `host_in_valid`  in  1  host offers `host_in_data`.
- `host_in_ready`  out  1  input FIFO not full.
- `mm_din`  out  WIDTH  head of the input FIFO; drives micromachine `din`.
- `mm_din_strb`  in  1  from micromachine `din_strb`; the word was consumed.
- `mm_dout`  in  WIDTH  from micromachine `dout`.
- `mm_dout_strb`  in  1  from micromachine `dout_strb`; `mm_dout` is valid.
- `host_out_data`  out  WIDTH  head of the output FIFO.
- `host_out_valid`  out  1  output FIFO not empty.
- `host_out_ready`  in  1  host accepts `host_out_data`.
- `clr_flags`  in  1  synchronous clear of the sticky flags.
- `underrun`  out  1  sticky: `mm_din_strb` arrived while the input FIFO was empty.
- `overflow`  out  1  sticky: `mm_dout_strb` arrived while the output FIFO was full and not draining.

## Operation
- **Input FIFO push:** a word is pushed on `host_in_valid && host_in_ready`. `host_in_ready = (in_count != DEPTH)`, decoded combinationally from the count.
- **`mm_din` presentation:** `mm_din` shows the current head word, not registered separately, and is 0 when the FIFO is empty. The machine samples `din` combinationally in its SBUS_IN cycle and reports `din_strb` one edge later, so the head must stay stable until that strobe.
- **Input FIFO pop:** `mm_din_strb` pops the head.
  - Strobe with `in_count == 0`: no pop; `underrun` is set.
  - Push and pop in the same cycle: count is unchanged; both pointers advance.
- **Output capture:** `mm_dout_strb` pushes `mm_dout`. Data and strobe are registered together on the machine side, so they are sampled on the same edge.
- **Output FIFO full:** a capture is accepted if the host pops in the same cycle (`host_out_ready && host_out_valid`). Otherwise the word is dropped and `overflow` is set.
- **Output FIFO pop:** the host pops on `host_out_valid && host_out_ready`. `host_out_data` shows the head word and is 0 when empty.
- **Sticky flags:** `underrun` and `overflow` hold until `clr_flags`. If `clr_flags` and a new error event occur in the same cycle, the flag ends up set.
- **Pointers and counts:** pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Counts are `$clog2(DEPTH)+1` bits.

## Timing
- **Reset:** asserting `rst` at any time, including mid-transfer, immediately clears both FIFOs (pointers and counts), `underrun` and `overflow`. Stored words are discarded. Reset output values:
  - `host_in_ready` = 1
  - `mm_din` = 0
  - `host_out_valid` = 0
  - `host_out_data` = 0
  - `underrun` = 0
  - `overflow` = 0
- **Host to machine:** one cycle. A word pushed at edge N appears on `mm_din` after edge N when the FIFO was empty.
- **Machine to host:** one cycle. A word captured at edge N raises `host_out_valid` after edge N.
- **Throughput:** one push and one pop per FIFO per cycle, sustained.
- **Flags:** both flags are registered and assert after the offending edge.

## Configuration
- **`MM_BRIDGE_STATS_EN` defined:** adds two output ports, `stat_in_words` and `stat_out_words`, each 16 bits.
  - They count accepted `mm_din_strb` pops and accepted output captures.
  - Both saturate at 16'hFFFF, reset to 0, and clear on `clr_flags`.
- **`MM_BRIDGE_STATS_EN` undefined:** the ports and counters are absent. All other behaviour is identical.

## Structure
- **Shared package:** `WORDLEN` comes from the shared `globals` package. Add `globals::BRIDGE_DEPTH` (default 4) there so that the micromachine top and the benches agree on depth.
- **Sub-module:** one natural sub-module, `mm_sync_fifo`, a show-ahead synchronous FIFO with an async active-high reset.
  - Ports: push, pop, din, head, count.
  - Instantiated twice, once per direction.
  - Overflow and underrun decisions and the sticky flags stay in `mm_io_bridge`.

## Test plan
- **Reset and idle:** assert `rst` mid-cycle -> all outputs take their reset values at once; `host_in_ready` = 1.
- **Input stream:** push 32'h11, 32'h22, 32'h33; pulse `mm_din_strb` three times -> `mm_din` shows 11, 22, 33 in order, then 0; `underrun` = 0.
- **Input full and underrun:** push `DEPTH` words -> `host_in_ready` = 0. A fifth `host_in_valid` is not accepted. Drain the FIFO, then one extra strobe -> `underrun` = 1, held until `clr_flags`.
- **Output capture:** strobe `mm_dout` 32'hA5, 32'h5A with `host_out_ready` = 0 -> `host_out_valid` = 1 and `host_out_data` = A5. Two host pops -> A5 then 5A, then `host_out_valid` = 0.
- **Output full edge cases:** fill the output FIFO, then strobe 32'hDEAD with `host_out_ready` = 0 -> `overflow` = 1 and DEAD is lost. Repeat with `host_out_ready` = 1 -> no overflow, and DEAD appears last.
- **Simultaneous events and stats:** push and pop the input FIFO in the same cycle at count 1 -> count stays 1. Under `MM_BRIDGE_STATS_EN`, `stat_in_words` increments per accepted pop and does not increment on an underrun strobe.

Source files
------------

// File: rtl/globals_pkg.sv
// Shared constants for the micromachine, its host bridge and the benches.
// Word length and bridge FIFO depth live here so every consumer agrees.
package globals;
  localparam int WORDLEN      = 32;
  localparam int BRIDGE_DEPTH = 4;
endpackage

// File: rtl/mm_sync_fifo.sv
// Show-ahead synchronous FIFO: head shows the oldest word (0 when empty).
// The caller must never push when full (unless also popping) or pop when empty.
module mm_sync_fifo #(
  parameter int WIDTH = globals::WORDLEN,
  parameter int DEPTH = globals::BRIDGE_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Simultaneous push and pop leaves the count alone.
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/mm_io_bridge.sv
// Host <-> micromachine strobe bridge: one FIFO per direction plus sticky flags.
// Define MM_BRIDGE_STATS_EN to add saturating 16-bit word counters.
module mm_io_bridge #(
  parameter int WIDTH = globals::WORDLEN,
  parameter int DEPTH = globals::BRIDGE_DEPTH,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] host_in_data,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  output logic [WIDTH-1:0] mm_din,
  input  logic             mm_din_strb,
  input  logic [WIDTH-1:0] mm_dout,
  input  logic             mm_dout_strb,
  output logic [WIDTH-1:0] host_out_data,
  output logic             host_out_valid,
  input  logic             host_out_ready,
  input  logic             clr_flags,
`ifdef MM_BRIDGE_STATS_EN
  output logic [15:0]      stat_in_words,
  output logic [15:0]      stat_out_words,
`endif
  output logic             underrun,
  output logic             overflow
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; the machine side uses single-cycle strobes with no back-pressure.

  logic [CW-1:0] in_count, out_count;
  logic          in_push, in_pop, out_push, out_pop, out_full;
  logic          underrun_evt, overflow_evt;
  logic          underrun_q, underrun_d;
  logic          overflow_q, overflow_d;

  assign host_in_ready  = (in_count != CW'(DEPTH));
  assign in_push        = host_in_valid && host_in_ready;
  assign in_pop         = mm_din_strb && (in_count != '0);
  assign underrun_evt   = mm_din_strb && (in_count == '0);

  assign host_out_valid = (out_count != '0);
  assign out_pop        = host_out_valid && host_out_ready;
  assign out_full       = (out_count == CW'(DEPTH));
  // A full FIFO still accepts a capture when the host frees a slot this cycle.
  assign out_push       = mm_dout_strb && (!out_full || out_pop);
  assign overflow_evt   = mm_dout_strb && out_full && !out_pop;

  mm_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_push),
    .pop   (in_pop),
    .din   (host_in_data),
    .head  (mm_din),
    .count (in_count)
  );

  mm_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_push),
    .pop   (out_pop),
    .din   (mm_dout),
    .head  (host_out_data),
    .count (out_count)
  );

  // A new error in the same cycle as clr_flags wins.
  always_comb begin
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    if (clr_flags) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end
    if (underrun_evt) underrun_d = 1'b1;
    if (overflow_evt) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign underrun = underrun_q;
  assign overflow = overflow_q;

`ifdef MM_BRIDGE_STATS_EN
  logic [15:0] stat_in_q, stat_in_d;
  logic [15:0] stat_out_q, stat_out_d;

  always_comb begin
    stat_in_d  = stat_in_q;
    stat_out_d = stat_out_q;
    if (clr_flags) begin
      stat_in_d  = '0;
      stat_out_d = '0;
    end else begin
      if (in_pop && stat_in_q != 16'hFFFF)    stat_in_d  = stat_in_q + 16'd1;
      if (out_push && stat_out_q != 16'hFFFF) stat_out_d = stat_out_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
    end else begin
      stat_in_q  <= stat_in_d;
      stat_out_q <= stat_out_d;
    end
  end

  assign stat_in_words  = stat_in_q;
  assign stat_out_words = stat_out_q;
`endif

endmodule
